// File: rtl/dplbuf_rd_ptr_mgmt.sv
// Consumer-side read pointer manager for a PFN ring: registers producer state,
// computes available blocks and issues one block read at a time.
module dplbuf_rd_ptr_mgmt #(
   parameter bit BALI = 1'b0
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iRST_PTR,
   input  logic        iEN,
   input  logic [31:0] iDPLBUF_START_PFN,
   input  logic [31:0] iDPLBUF_LAST_PFN,
   input  logic [31:0] iDPLBUF_WR_PTR,
   output logic        oRD_REQ,
   output logic [31:0] oRD_PFN,
   input  logic        iRD_ACK,
   input  logic        iRD_DONE,
   output logic [31:0] oDPLBUF_RD_PTR,
   output logic [31:0] oDPLBUF_AVAIL,
   output logic        oDPLBUF_EMPTY,
   output logic [31:0] oRD_CNT,
   output logic        oPTR_ERR
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_BUSY,
      ST_ADV,
      ST_WAIT,
      ST_DRAIN
   } state_t;

   // Cycles from a rd_ptr update until the exported avail reflects it.
   localparam logic [1:0] SETTLE = BALI ? 2'd2 : 2'd1;

   logic [31:0] start_q, last_q, wr_q;
   logic [31:0] depth, avail_c;
   logic        wr_in_range;
   logic [31:0] avail_q, avail_o;
   logic        empty_q, empty_o;

   state_t      state_q, state_d;
   logic        rd_req_q, rd_req_d;
   logic [31:0] rd_pfn_q, rd_pfn_d;
   logic [31:0] rd_ptr_q, rd_ptr_d;
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [1:0]  holdoff_q, holdoff_d;
   logic [31:0] rd_ptr_out_q;
   logic        ptr_err_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         start_q <= '0;
         last_q  <= '0;
         wr_q    <= '0;
      end else begin
         start_q <= iDPLBUF_START_PFN;
         last_q  <= iDPLBUF_LAST_PFN;
         wr_q    <= iDPLBUF_WR_PTR;
      end
   end

   assign depth       = last_q - start_q + 32'd1;
   assign wr_in_range = (wr_q >= start_q) && (wr_q <= last_q);

   // Wrapped case: (last - rd + 1) + (wr - start) == depth - (rd - wr), modulo 2^32.
   always_comb begin
      avail_c = '0;
      if (wr_in_range) begin
         if (wr_q >= rd_ptr_q) avail_c = wr_q - rd_ptr_q;
         else                  avail_c = depth - (rd_ptr_q - wr_q);
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         avail_q <= '0;
         empty_q <= 1'b1;
      end else begin
         avail_q <= avail_c;
         empty_q <= (avail_c == '0);
      end
   end

   if (BALI) begin : g_bali_flop
      always_ff @(posedge iCLK or posedge iRST) begin
         if (iRST) begin
            avail_o <= '0;
            empty_o <= 1'b1;
         end else begin
            avail_o <= avail_q;
            empty_o <= empty_q;
         end
      end
   end else begin : g_no_bali_flop
      assign avail_o = avail_q;
      assign empty_o = empty_q;
   end

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      state_d   = state_q;
      rd_req_d  = rd_req_q;
      rd_pfn_d  = rd_pfn_q;
      rd_ptr_d  = rd_ptr_q;
      rd_cnt_d  = rd_cnt_q;
      holdoff_d = (holdoff_q != 2'd0) ? holdoff_q - 2'd1 : 2'd0;

      unique case (state_q)
         ST_IDLE: begin
            if (iEN && !empty_o && (holdoff_q == 2'd0)) begin
               state_d  = ST_REQ;
               rd_req_d = 1'b1;
               rd_pfn_d = rd_ptr_q;
            end
         end
         ST_REQ: begin
            if (iRD_ACK) begin
               rd_req_d = 1'b0;
               state_d  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (iRD_DONE) state_d = ST_ADV;
         end
         ST_ADV: begin
            rd_ptr_d  = (rd_ptr_q == last_q) ? start_q : rd_ptr_q + 32'd1;
            rd_cnt_d  = rd_cnt_q + 32'd1;
            holdoff_d = SETTLE;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            if (holdoff_q <= 2'd1) state_d = ST_IDLE;
         end
         ST_DRAIN: begin
            if (iRD_DONE) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Pointer reload overrides everything; the holdoff keeps IDLE from
      // trusting an avail value computed against the old pointer.
      if (iRST_PTR) begin
         rd_ptr_d  = start_q;
         rd_cnt_d  = rd_cnt_q;
         rd_req_d  = 1'b0;
         holdoff_d = SETTLE;
         unique case (state_q)
            ST_REQ:   state_d = iRD_ACK  ? ST_DRAIN : ST_IDLE;
            ST_BUSY:  state_d = iRD_DONE ? ST_IDLE  : ST_DRAIN;
            ST_DRAIN: state_d = iRD_DONE ? ST_IDLE  : ST_DRAIN;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q      <= ST_IDLE;
         rd_req_q     <= 1'b0;
         rd_pfn_q     <= '0;
         rd_ptr_q     <= '0;
         rd_cnt_q     <= '0;
         holdoff_q    <= 2'd0;
         rd_ptr_out_q <= '0;
      end else begin
         state_q      <= state_d;
         rd_req_q     <= rd_req_d;
         rd_pfn_q     <= rd_pfn_d;
         rd_ptr_q     <= rd_ptr_d;
         rd_cnt_q     <= rd_cnt_d;
         holdoff_q    <= holdoff_d;
         rd_ptr_out_q <= rd_ptr_q;
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST)              ptr_err_q <= 1'b0;
      else if (iRST_PTR)     ptr_err_q <= 1'b0;
      else if (!wr_in_range) ptr_err_q <= 1'b1;
   end

   assign oRD_REQ        = rd_req_q;
   assign oRD_PFN        = rd_pfn_q;
   assign oDPLBUF_RD_PTR = rd_ptr_out_q;
   assign oDPLBUF_AVAIL  = avail_o;
   assign oDPLBUF_EMPTY  = empty_o;
   assign oRD_CNT        = rd_cnt_q;
   assign oPTR_ERR       = ptr_err_q;

endmodule
